// File: rtl/opt_link_pkg.sv
// rtl/opt_link_pkg.sv - shared types and threshold defaults for the optical link supervisor
package opt_link_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_ACTIVE0 = 3'd1,
        ST_ACTIVE1 = 3'd2,
        ST_SWITCH  = 3'd3,
        ST_FAULT   = 3'd4
    } link_state_t;

    typedef logic ch_t;

    localparam int FAIL_FILT_DEF   = 16;
    localparam int GOOD_FRAMES_DEF = 3;
    localparam int BLANK_TIME_DEF  = 500;
    localparam int REVERT_TIME_DEF = 10000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/opt_link_supervisor_if.sv
// rtl/opt_link_supervisor_if.sv - line status inputs and selection outputs of the link supervisor
//   i_brk/i_err/i_fs_start [ch1,ch0] : per-channel line break, frame timeout, frame-start strobe
//   i_force_en/i_force_sel           : manual channel selection request
//   o_sel/o_link_ok/o_blank          : active channel, link usable, discard data
//   o_unhealthy [ch1,ch0]            : per-channel unhealthy flags
//   o_switch_cnt                     : completed switches, saturating
//   slave modport: supervisor side; master modport: line/host side
interface opt_link_supervisor_if;
    logic [1:0] i_brk;
    logic [1:0] i_err;
    logic [1:0] i_fs_start;
    logic       i_force_en;
    logic       i_force_sel;
    logic       o_sel;
    logic       o_link_ok;
    logic       o_blank;
    logic [1:0] o_unhealthy;
    logic [7:0] o_switch_cnt;

    modport slave (
        input  i_brk, i_err, i_fs_start, i_force_en, i_force_sel,
        output o_sel, o_link_ok, o_blank, o_unhealthy, o_switch_cnt
    );

    modport master (
        output i_brk, i_err, i_fs_start, i_force_en, i_force_sel,
        input  o_sel, o_link_ok, o_blank, o_unhealthy, o_switch_cnt
    );
endinterface

// File: rtl/opt_chan_health.sv
// rtl/opt_chan_health.sv - per-channel health filter (fail filter and good-frame qualifier)
//   i_clk_100M, i_reset_n : clock, synchronous active-low reset
//   i_brk, i_err          : line break / frame timeout for this channel
//   i_fs_start            : frame-start strobe, rising edge counted
//   o_unhealthy           : registered unhealthy flag, set out of reset
module opt_chan_health
    import opt_link_pkg::*;
#(
    parameter int FAIL_FILT   = FAIL_FILT_DEF,
    parameter int GOOD_FRAMES = GOOD_FRAMES_DEF
) (
    input  logic i_clk_100M,
    input  logic i_reset_n,
    input  logic i_brk,
    input  logic i_err,
    input  logic i_fs_start,
    output logic o_unhealthy
);

    localparam int FW = $clog2(FAIL_FILT + 1);
    localparam int GW = $clog2(GOOD_FRAMES + 1);

    logic [FW-1:0] fail_cnt;
    logic [GW-1:0] good_cnt;
    logic          fs_d;
    logic          bad;
    logic          fs_rise;
    logic          fail_full;
    logic          good_full;

    assign bad       = i_brk | i_err;
    assign fs_rise   = i_fs_start & ~fs_d;
    assign fail_full = (fail_cnt == FW'(FAIL_FILT));
    assign good_full = (good_cnt == GW'(GOOD_FRAMES));

    always_ff @(posedge i_clk_100M) begin
        if (!i_reset_n) begin
            fail_cnt    <= '0;
            good_cnt    <= '0;
            fs_d        <= 1'b0;
            o_unhealthy <= 1'b1;
        end else begin
            fs_d <= i_fs_start;
            if (bad) begin
                if (!fail_full)
                    fail_cnt <= fail_cnt + 1'b1;
                good_cnt <= '0;
            end else begin
                fail_cnt <= '0;
                if (fs_rise && !good_full)
                    good_cnt <= good_cnt + 1'b1;
            end
            // Flags follow the registered counters, so they change one cycle
            // after a threshold is reached; failure wins if both are full.
            if (fail_full)
                o_unhealthy <= 1'b1;
            else if (good_full)
                o_unhealthy <= 1'b0;
        end
    end

endmodule

// File: rtl/opt_link_supervisor.sv
// rtl/opt_link_supervisor.sv - dual-channel optical link selection with failover, force and blanking
//   i_clk_100M, i_reset_n : 100 MHz clock, synchronous active-low reset
//   lnk (slave)           : line status in, selection/status out
//   OPT_REVERT_EN         : when defined, ACTIVE1 returns to ch0 after ch0 has been
//                           healthy for REVERT_TIME cycles (blocked by force to ch1)
module opt_link_supervisor
    import opt_link_pkg::*;
#(
    parameter int FAIL_FILT   = FAIL_FILT_DEF,
    parameter int GOOD_FRAMES = GOOD_FRAMES_DEF,
    parameter int BLANK_TIME  = BLANK_TIME_DEF,
    parameter int REVERT_TIME = REVERT_TIME_DEF
) (
    input  logic                   i_clk_100M,
    input  logic                   i_reset_n,
    opt_link_supervisor_if.slave   lnk
);

    localparam int BW = $clog2(BLANK_TIME);

    logic [1:0]  unhealthy;
    logic [1:0]  healthy;
    link_state_t state;
    logic        sel;
    logic        link_ok;
    logic        blank;
    logic [7:0]  switch_cnt;
    logic [BW-1:0] blank_cnt;

    logic go_sw;
    logic go_fault;
    logic go_active;
    ch_t  sw_tgt;

    for (genvar ch = 0; ch < 2; ch++) begin : g_health
        opt_chan_health #(
            .FAIL_FILT   (FAIL_FILT),
            .GOOD_FRAMES (GOOD_FRAMES)
        ) u_health (
            .i_clk_100M  (i_clk_100M),
            .i_reset_n   (i_reset_n),
            .i_brk       (lnk.i_brk[ch]),
            .i_err       (lnk.i_err[ch]),
            .i_fs_start  (lnk.i_fs_start[ch]),
            .o_unhealthy (unhealthy[ch])
        );
    end

    assign healthy = ~unhealthy;

`ifdef OPT_REVERT_EN
    localparam int RW = $clog2(REVERT_TIME);
    logic [RW-1:0] rev_cnt;
    logic          rev_run;
    logic          rev_due;

    // Revert timer only runs in ACTIVE1 while ch0 is healthy and no force to ch1 holds it off.
    assign rev_run = (state == ST_ACTIVE1) && healthy[0] && !(lnk.i_force_en && lnk.i_force_sel);
    assign rev_due = rev_run && (rev_cnt == RW'(REVERT_TIME - 1));

    always_ff @(posedge i_clk_100M) begin
        if (!i_reset_n)
            rev_cnt <= '0;
        else if (rev_run && !go_sw && !go_fault)
            rev_cnt <= rev_cnt + 1'b1;
        else
            rev_cnt <= '0;
    end
`else
    logic rev_due;
    assign rev_due = 1'b0;
`endif

    // o_sel doubles as the switch target while in SWITCH.
    always_comb begin
        go_sw     = 1'b0;
        go_fault  = 1'b0;
        go_active = 1'b0;
        sw_tgt    = sel;
        case (state)
            ST_INIT: begin
                if (healthy != 2'b00) begin
                    go_sw  = 1'b1;
                    sw_tgt = healthy[0] ? 1'b0 : 1'b1;
                end
            end
            ST_ACTIVE0, ST_ACTIVE1: begin
                // Health failover is evaluated before any force request.
                if (!healthy[sel]) begin
                    if (healthy[~sel]) begin
                        go_sw  = 1'b1;
                        sw_tgt = ~sel;
                    end else begin
                        go_fault = 1'b1;
                    end
                end else if (lnk.i_force_en && (lnk.i_force_sel != sel) && healthy[lnk.i_force_sel]) begin
                    go_sw  = 1'b1;
                    sw_tgt = lnk.i_force_sel;
                end else if (rev_due) begin
                    go_sw  = 1'b1;
                    sw_tgt = 1'b0;
                end
            end
            ST_SWITCH: begin
                if (!healthy[sel]) begin
                    if (healthy[~sel]) begin
                        go_sw  = 1'b1;
                        sw_tgt = ~sel;
                    end else begin
                        go_fault = 1'b1;
                    end
                end else if (blank_cnt == BW'(BLANK_TIME - 1)) begin
                    go_active = 1'b1;
                end
            end
            ST_FAULT: begin
                if (healthy[0]) begin
                    go_sw  = 1'b1;
                    sw_tgt = 1'b0;
                end else if (healthy[1]) begin
                    go_sw  = 1'b1;
                    sw_tgt = 1'b1;
                end
            end
            default: go_fault = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk_100M) begin
        if (!i_reset_n) begin
            state      <= ST_INIT;
            sel        <= 1'b0;
            link_ok    <= 1'b0;
            blank      <= 1'b1;
            switch_cnt <= 8'd0;
            blank_cnt  <= '0;
        end else if (go_fault) begin
            state     <= ST_FAULT;
            link_ok   <= 1'b0;
            blank     <= 1'b1;
            blank_cnt <= '0;
        end else if (go_sw) begin
            // Entering (or re-targeting within) SWITCH restarts the blanking window.
            state     <= ST_SWITCH;
            sel       <= sw_tgt;
            link_ok   <= 1'b0;
            blank     <= 1'b1;
            blank_cnt <= '0;
        end else if (go_active) begin
            state      <= sel ? ST_ACTIVE1 : ST_ACTIVE0;
            link_ok    <= 1'b1;
            blank      <= 1'b0;
            switch_cnt <= sat_inc8(switch_cnt);
            blank_cnt  <= '0;
        end else if (state == ST_SWITCH) begin
            blank_cnt <= blank_cnt + 1'b1;
        end
    end

    assign lnk.o_sel        = sel;
    assign lnk.o_link_ok    = link_ok;
    assign lnk.o_blank      = blank;
    assign lnk.o_unhealthy  = unhealthy;
    assign lnk.o_switch_cnt = switch_cnt;

endmodule

// File: tb/tb_opt_link_supervisor.sv
// tb/tb_opt_link_supervisor.sv - scoreboard testbench for opt_link_supervisor
module tb_opt_link_supervisor;

    localparam int B   = 500;
    localparam int REV = 10000;

    typedef struct {
        logic [12:0] v;
        int          gap;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   n_total;
    int   n_pass;
    int   cyc;
    int   last_cyc;
    bit   mon_en;
    logic [12:0] prev;
    logic [12:0] cur;

    opt_link_supervisor_if lnk();

    opt_link_supervisor dut (
        .i_clk_100M (clk),
        .i_reset_n  (rst_n),
        .lnk        (lnk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] tup(logic [1:0] u, logic s, logic l, logic b, logic [7:0] c);
        return {u, s, l, b, c};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_ev(logic [1:0] u, logic s, logic l, logic b, logic [7:0] c, int gap);
        exp_t e;
        e.v   = tup(u, s, l, b, c);
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Monitor: every change of the output tuple is one DUT event, checked against the queue.
    initial begin
        exp_t e;
        cyc = 0;
        last_cyc = 0;
        prev = 'x;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {lnk.o_unhealthy, lnk.o_sel, lnk.o_link_ok, lnk.o_blank, lnk.o_switch_cnt};
            if (mon_en && cur !== prev) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_event: got %0h at cycle %0d, nothing expected", cur, cyc);
                end else begin
                    e = sb.pop_front();
                    check("event_value", {19'd0, cur}, {19'd0, e.v});
                    if (e.gap >= 0) check("event_gap", cyc - last_cyc, e.gap);
                end
                last_cyc = cyc;
            end
            prev = cur;
        end
    end

    task automatic drain(int maxc);
        int c = 0;
        while (sb.size() != 0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d events still pending", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(logic [1:0] ch);
        repeat (3) begin
            @(negedge clk); lnk.i_fs_start = ch;
            @(negedge clk); lnk.i_fs_start = 2'b00;
        end
    endtask

    task automatic bad_for(logic [1:0] brk, logic [1:0] err, int n);
        @(negedge clk);
        lnk.i_brk = brk;
        lnk.i_err = err;
        repeat (n) @(negedge clk);
        lnk.i_brk = 2'b00;
        lnk.i_err = 2'b00;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        mon_en  = 1'b0;
        rst_n   = 1'b0;
        lnk.i_brk = 2'b00;
        lnk.i_err = 2'b00;
        lnk.i_fs_start = 2'b00;
        lnk.i_force_en = 1'b0;
        lnk.i_force_sel = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_tuple", {19'd0, lnk.o_unhealthy, lnk.o_sel, lnk.o_link_ok, lnk.o_blank, lnk.o_switch_cnt},
              {19'd0, tup(2'b11, 1'b0, 1'b0, 1'b1, 8'd0)});
        rst_n = 1'b1;
        mon_en = 1'b1;
        last_cyc = cyc;

        // ch0 qualifies: INIT -> SWITCH(0) -> ACTIVE0
        expect_ev(2'b10, 1'b0, 1'b0, 1'b1, 8'd0, -1);
        expect_ev(2'b10, 1'b0, 1'b1, 1'b0, 8'd1, 1 + B);
        frames(2'b01);
        drain(1200);
        check("active0_link_ok", {31'd0, lnk.o_link_ok}, 32'd1);

        // ch1 qualifies, no state change
        expect_ev(2'b00, 1'b0, 1'b1, 1'b0, 8'd1, -1);
        frames(2'b10);
        drain(200);

        // 15 error cycles stay below the fail filter
        bad_for(2'b00, 2'b01, 15);
        repeat (20) @(negedge clk);
        check("err15_unhealthy", {30'd0, lnk.o_unhealthy}, 32'd0);

        // 16 break cycles on ch0: failover to ch1
        expect_ev(2'b01, 1'b0, 1'b1, 1'b0, 8'd1, -1);
        expect_ev(2'b01, 1'b1, 1'b0, 1'b1, 8'd1, 1);
        expect_ev(2'b01, 1'b1, 1'b1, 1'b0, 8'd2, B);
        bad_for(2'b01, 2'b00, 16);
        drain(1200);

        // Force to unhealthy ch0 ignored; honoured once ch0 qualifies
        lnk.i_force_en = 1'b1;
        lnk.i_force_sel = 1'b0;
        repeat (20) @(negedge clk);
        check("force_unhealthy_sel", {31'd0, lnk.o_sel}, 32'd1);
        expect_ev(2'b00, 1'b1, 1'b1, 1'b0, 8'd2, -1);
        expect_ev(2'b00, 1'b0, 1'b0, 1'b1, 8'd2, 1);
        expect_ev(2'b00, 1'b0, 1'b1, 1'b0, 8'd3, B);
        frames(2'b01);
        drain(1200);
        lnk.i_force_en = 1'b0;

        // ch1 breaks while standby; force to it ignored, then honoured after recovery
        expect_ev(2'b10, 1'b0, 1'b1, 1'b0, 8'd3, -1);
        bad_for(2'b10, 2'b00, 16);
        drain(200);
        lnk.i_force_en = 1'b1;
        lnk.i_force_sel = 1'b1;
        repeat (20) @(negedge clk);
        check("force_ch1_unhealthy_sel", {31'd0, lnk.o_sel}, 32'd0);
        expect_ev(2'b00, 1'b0, 1'b1, 1'b0, 8'd3, -1);
        expect_ev(2'b00, 1'b1, 1'b0, 1'b1, 8'd3, 1);
        expect_ev(2'b00, 1'b1, 1'b1, 1'b0, 8'd4, B);
        frames(2'b10);
        drain(1200);
        lnk.i_force_en = 1'b0;

        // Both channels break: FAULT; ch1 recovers: SWITCH(1) -> ACTIVE1
        expect_ev(2'b11, 1'b1, 1'b1, 1'b0, 8'd4, -1);
        expect_ev(2'b11, 1'b1, 1'b0, 1'b1, 8'd4, 1);
        bad_for(2'b11, 2'b00, 16);
        drain(200);
        check("fault_blank", {31'd0, lnk.o_blank}, 32'd1);
        expect_ev(2'b01, 1'b1, 1'b0, 1'b1, 8'd4, -1);
        expect_ev(2'b01, 1'b1, 1'b1, 1'b0, 8'd5, 1 + B);
        frames(2'b10);
        drain(1200);

        // Target ch0 fails during SWITCH: re-target ch1, blanking restarts
        expect_ev(2'b00, 1'b1, 1'b1, 1'b0, 8'd5, -1);
        frames(2'b01);
        drain(200);
        expect_ev(2'b00, 1'b0, 1'b0, 1'b1, 8'd5, -1);
        lnk.i_force_sel = 1'b0;
        lnk.i_force_en = 1'b1;
        drain(50);
        expect_ev(2'b01, 1'b0, 1'b0, 1'b1, 8'd5, -1);
        expect_ev(2'b01, 1'b1, 1'b0, 1'b1, 8'd5, 1);
        expect_ev(2'b01, 1'b1, 1'b1, 1'b0, 8'd6, B);
        bad_for(2'b01, 2'b00, 16);
        drain(1200);
        lnk.i_force_en = 1'b0;

        // Reset in the middle of a SWITCH aborts to INIT without counting
        expect_ev(2'b00, 1'b1, 1'b1, 1'b0, 8'd6, -1);
        frames(2'b01);
        drain(200);
        expect_ev(2'b00, 1'b0, 1'b0, 1'b1, 8'd6, -1);
        lnk.i_force_en = 1'b1;
        drain(50);
        lnk.i_force_en = 1'b0;
        repeat (100) @(negedge clk);
        expect_ev(2'b11, 1'b0, 1'b0, 1'b1, 8'd0, -1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midswitch_reset_cnt", {24'd0, lnk.o_switch_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        drain(10);

        // Both channels qualify together: ch0 wins
        expect_ev(2'b00, 1'b0, 1'b0, 1'b1, 8'd0, -1);
        expect_ev(2'b00, 1'b0, 1'b1, 1'b0, 8'd1, 1 + B);
        frames(2'b11);
        drain(1200);
        check("tie_sel", {31'd0, lnk.o_sel}, 32'd0);

`ifdef OPT_REVERT_EN
        // Forced to ch1, then automatic revert to ch0 after the hold time
        expect_ev(2'b00, 1'b1, 1'b0, 1'b1, 8'd1, -1);
        lnk.i_force_sel = 1'b1;
        lnk.i_force_en = 1'b1;
        drain(50);
        lnk.i_force_en = 1'b0;
        expect_ev(2'b00, 1'b1, 1'b1, 1'b0, 8'd2, B);
        expect_ev(2'b00, 1'b0, 1'b0, 1'b1, 8'd2, REV);
        expect_ev(2'b00, 1'b0, 1'b1, 1'b0, 8'd3, B);
        drain(12000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
